md_scheduler: RTL
=================

// Module: md_scheduler
// PURPOSE
//   Sequences the iterative multiply/divide unit in the E stage and owns the HI/LO registers.
//   Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO per start pulse and runs a fixed-latency busy window.
//   Drives the 3-bit busy vector consumed by the E-stage pipeline registers (hold while busy!=0).
//   Generates md_stall for the D stage when an HI/LO-using instruction must wait.
// PARAMETERS
//   WIDTH        32  operand / HI / LO width
//   MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//   DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1, >=MULT_CYCLES)
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high; clears all state
//   start      in   1      E-stage md instruction valid this cycle
//   md_op      in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   rs_val     in   WIDTH  operand A / MTHI/MTLO source
//   rt_val     in   WIDTH  operand B
//   d_uses_md  in   1      D-stage instr is MULT*/DIV*/MT*/MF*
//   hi         out  WIDTH  HI register
//   lo         out  WIDTH  LO register
//   busy       out  3      [2] DIV active, [1] MULT active, [0] final busy cycle
//   md_stall   out  1      D-stage stall request
// BEHAVIOUR
//   - Reset (async): state=IDLE, cnt=0, hi=lo=0, busy=3'b000, md_stall=0 next combinational eval.
//   - States: IDLE, MULT, DIV. cnt is a down-counter wide enough for DIV_CYCLES-1.
//   - IDLE & start & op MULT/MULTU: operands latched, result computed (64-bit), state->MULT,
//     cnt=MULT_CYCLES-1. op DIV/DIVU: state->DIV, cnt=DIV_CYCLES-1.
//   - IDLE & start & MTHI: hi<=rs_val at that edge; MTLO: lo<=rs_val; state stays IDLE, no busy.
//   - start with op 6/7: ignored. start while not IDLE: ignored (upstream guarantees via md_stall).
//   - MULT/DIV: cnt decrements each edge; at edge with cnt==0, {hi,lo}<=stored result, state->IDLE.
//   - busy is registered-state derived: busy[1]=(state==MULT), busy[2]=(state==DIV),
//     busy[0]=(state!=IDLE)&(cnt==0). busy asserted exactly MULT_CYCLES / DIV_CYCLES cycles,
//     beginning the cycle after the start edge. New hi/lo visible the first cycle busy==0.
//   - MULT: signed 32x32->64, hi=upper, lo=lower. MULTU: unsigned.
//   - DIV: signed, quotient truncates toward zero -> lo, remainder (sign of dividend) -> hi.
//     DIVU: unsigned. Overflow 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0.
//   - Divide by zero (rt_val==0): full DIV busy window runs, hi/lo left unchanged at the end.
//   - md_stall = d_uses_md & ((state!=IDLE) | (start & md_op<=3)). Combinational.
//   - Operands are captured at the start edge; later changes on rs_val/rt_val have no effect.
//   - Reset asserted mid-operation: operation abandoned, hi/lo=0, busy=0 immediately.
//   - Back-to-back: a start on the first cycle with busy==0 is accepted normally.
// TESTING
//   - Reset then idle: hi=lo=0, busy=0, md_stall=0 with d_uses_md=1, start=0.
//   - MULT rs=0xFFFFFFFE(-2) rt=3: busy=3'b010 for 4 cycles, 3'b011 on 5th; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//   - MULTU rs=0xFFFFFFFF rt=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
//   - DIV rs=-7 rt=2 -> busy[2] for 10 cycles, lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1); DIVU 7/0 -> hi/lo unchanged.
//   - MTHI 0x1234 while idle -> hi=0x1234 next edge, busy stays 0; d_uses_md=1 during MULT -> md_stall=1 until busy==0.
//   - Reset pulse at cycle 3 of DIV -> busy=0, hi=lo=0 immediately; following MULT 2*3 gives lo=6.

Source files
------------

// File: rtl/md_scheduler.sv
// -----------------------------------------------------------------------------
// md_scheduler
//   Sequences the multiply/divide unit in the E stage and owns the HI/LO
//   registers. Each accepted MULT/MULTU/DIV/DIVU computes its 64-bit result at
//   the start edge and holds it for a fixed busy window. At the end of that
//   window the result is written into {hi, lo}. MTHI/MTLO write hi/lo directly
//   and do not open a busy window.
//
//   Ports
//     clk        rising-edge clock
//     reset      asynchronous, active-high; clears all state
//     start      E-stage md instruction valid this cycle
//     md_op      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//     rs_val     operand A / MTHI-MTLO source
//     rt_val     operand B
//     d_uses_md  D-stage instruction touches the md unit or HI/LO
//     hi, lo     architectural HI/LO registers
//     busy       [2] DIV active, [1] MULT active, [0] final busy cycle
//     md_stall   combinational D-stage stall request
// -----------------------------------------------------------------------------
module md_scheduler #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             d_uses_md,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [2:0]       busy,
  output logic             md_stall
);

  // Counter holds values 0 .. DIV_CYCLES-1.
  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] res_q;
  logic              res_dz_q;

  logic              load_mul;
  logic              load_div;
  logic              commit;
  logic              wr_hi;
  logic              wr_lo;

  // ---------------------------------------------------------------------------
  // Datapath: result computed from the live operands, captured at the start edge
  // ---------------------------------------------------------------------------
  logic              mul_signed;
  logic [2*WIDTH-1:0] mul_a;
  logic [2*WIDTH-1:0] mul_b;
  logic [2*WIDTH-1:0] mul_p;

  // Sign- or zero-extending to 2*WIDTH lets one unsigned multiplier produce
  // the correct low 2*WIDTH bits for both MULT and MULTU.
  assign mul_signed = (md_op == OP_MULT);
  assign mul_a = {{WIDTH{mul_signed & rs_val[WIDTH-1]}}, rs_val};
  assign mul_b = {{WIDTH{mul_signed & rt_val[WIDTH-1]}}, rt_val};
  assign mul_p = mul_a * mul_b;

  logic              div_signed;
  logic              a_neg, b_neg;
  logic [WIDTH-1:0]  a_mag, b_mag, b_safe;
  logic [WIDTH-1:0]  q_mag, r_mag;
  logic [WIDTH-1:0]  quo, rem;
  logic              div_zero;

  // Signed divide is done on magnitudes and re-signed afterwards: quotient
  // truncates toward zero, remainder takes the dividend's sign. The overflow
  // case MIN / -1 falls out naturally as quotient MIN, remainder 0.
  assign div_signed = (md_op == OP_DIV);
  assign a_neg      = div_signed & rs_val[WIDTH-1];
  assign b_neg      = div_signed & rt_val[WIDTH-1];
  assign a_mag      = a_neg ? (~rs_val + 1'b1) : rs_val;
  assign b_mag      = b_neg ? (~rt_val + 1'b1) : rt_val;
  assign div_zero   = (rt_val == '0);
  // Divisor forced non-zero so the divider never sees x/0; the result is
  // discarded in that case anyway.
  assign b_safe     = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
  assign q_mag      = a_mag / b_safe;
  assign r_mag      = a_mag % b_safe;
  assign quo        = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
  assign rem        = a_neg ? (~r_mag + 1'b1) : r_mag;

  // ---------------------------------------------------------------------------
  // Control FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_mul = 1'b0;
    load_div = 1'b0;
    commit   = 1'b0;
    wr_hi    = 1'b0;
    wr_lo    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (md_op)
            OP_MULT, OP_MULTU: begin
              state_d  = S_MULT;
              cnt_d    = CW'(MULT_CYCLES - 1);
              load_mul = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              state_d  = S_DIV;
              cnt_d    = CW'(DIV_CYCLES - 1);
              load_div = 1'b1;
            end
            OP_MTHI: wr_hi = 1'b1;
            OP_MTLO: wr_lo = 1'b1;
            default: ;  // 6/7 are no-ops
          endcase
        end
      end
      S_MULT, S_DIV: begin
        // A start here is ignored; upstream is held off by md_stall.
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counter and captured result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      res_q    <= '0;
      res_dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_mul) begin
        res_q    <= mul_p;
        res_dz_q <= 1'b0;
      end else if (load_div) begin
        res_q    <= {rem, quo};
        res_dz_q <= div_zero;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // HI/LO registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      // Divide by zero runs the full window but leaves HI/LO untouched.
      if (!res_dz_q) begin
        hi <= res_q[2*WIDTH-1:WIDTH];
        lo <= res_q[WIDTH-1:0];
      end
    end else begin
      if (wr_hi) hi <= rs_val;
      if (wr_lo) lo <= rs_val;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy[2] = (state_q == S_DIV);
  assign busy[1] = (state_q == S_MULT);
  assign busy[0] = (state_q != S_IDLE) && (cnt_q == '0);

  // Stall covers both an operation in flight and one being launched this cycle.
  assign md_stall = d_uses_md & ((state_q != S_IDLE) | (start & (md_op <= OP_DIVU)));

endmodule
